alu_op_sequencer: RTL and testbench

//  Issue stage directly upstream of the ALU. Accepts one decoded op (op_mne

---
 rtl/alu_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue stage in front of a combinational ALU.
// Accepts one decoded op over valid/ready and drives the ALU operand/op
// inputs. Multi-bit LSH/RSH run as repeated 1-bit ALU shifts, with each
// ALU result fed back as the next operand. The final result is returned
// downstream over valid/ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready
// are both high; the producer holds valid and payload stable until that
// edge, and ready may depend on state but never on valid.
module alu_op_sequencer #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic [CW-1:0] in_cnt,
  output logic [3:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_err,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  localparam int RW = $clog2(W + 1);

  localparam logic [3:0] OP_LSH = 4'd1;
  localparam logic [3:0] OP_RSH = 4'd2;
  localparam logic [3:0] OP_CLR = 4'd7;
  localparam logic [3:0] OP_MAX = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic           out_err_q, out_err_d;

  logic           accept;
  logic           in_illegal;
  logic           in_shift;
  logic           cnt_zero;
  logic [RW-1:0]  cnt_clamped;

  assign accept      = in_valid && (state_q == S_IDLE);
  assign in_illegal  = in_op > OP_MAX;
  assign in_shift    = (in_op == OP_LSH) || (in_op == OP_RSH);
  assign cnt_zero    = (in_cnt == '0);
  // Shifting by W or more always ends in the same place as W steps.
  assign cnt_clamped = (32'(in_cnt) > 32'(W)) ? RW'(W) : RW'(in_cnt);

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (in_illegal)                state_d = S_DONE;
          else if (in_shift && cnt_zero) state_d = S_DONE;
          else if (in_shift)             state_d = S_SHIFT;
          else                           state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = S_DONE;
      S_SHIFT: if (rem_q == RW'(1)) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: latched op/operands, shift accumulator, result.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      op_q       <= OP_CLR;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  // Datapath next values; the error flag only changes on an accept.
  always_comb begin
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = in_op;
          a_d  = in_a;
          b_d  = in_b;
          if (in_illegal) begin
            out_data_d = '0;
            out_err_d  = 1'b1;
          end else begin
            out_err_d = 1'b0;
            if (in_shift && cnt_zero) begin
              out_data_d = in_a;
            end else if (in_shift) begin
              acc_d = in_a;
              rem_d = cnt_clamped;
            end
          end
        end
      end
      S_EXEC: out_data_d = alu_out;
      S_SHIFT: begin
        acc_d = alu_out;
        rem_d = rem_q - RW'(1);
        if (rem_q == RW'(1)) out_data_d = alu_out;
      end
      default: ;
    endcase
  end

  // Outputs: the ALU sees CLR with zero operands unless an op is executing.
  always_comb begin
    alu_op    = OP_CLR;
    alu_a     = '0;
    alu_b     = '0;
    case (state_q)
      S_EXEC: begin
        alu_op = op_q;
        alu_a  = a_q;
        alu_b  = b_q;
      end
      S_SHIFT: begin
        alu_op = op_q;
        alu_a  = acc_q;
      end
      default: ;
    endcase
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
    out_data  = out_data_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU closes the loop on
// alu_op/alu_a/alu_b -> alu_out; directed ops push hand-computed results
// into an expected queue that a negedge monitor checks on each output.
module tb_alu_op_sequencer;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [CW-1:0] in_cnt;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_out;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_err;
  logic          busy;
  logic [1:0]    state_dbg;

  alu_op_sequencer #(.W(W), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_cnt(in_cnt),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // behavioural ALU: 1-bit shifts, XORA inverts operand A
  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_a + alu_b;
      4'd1:    alu_out = alu_a << 1;
      4'd2:    alu_out = alu_a >> 1;
      4'd3:    alu_out = alu_a | alu_b;
      4'd4:    alu_out = alu_a ^ alu_b;
      4'd5:    alu_out = alu_a & alu_b;
      4'd6:    alu_out = alu_a - alu_b;
      4'd8:    alu_out = alu_a ^ 8'hFF;
      default: alu_out = '0;
    endcase
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic         err_q[$];
  int           lat_q[$];
  int           acc_q[$];
  int           n_vec = 0;
  int           n_bad = 0;
  logic         mon_seen = 1'b0;
  logic [W-1:0] held_data;
  logic         held_err;
  int           nonclr_cycles = 0;
  int           lsh_cycles = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // monitor: latency at first out_valid, hold while stalled, data/err at transfer
  always @(negedge Clk) begin
    if (Reset) begin
      mon_seen = 1'b0;
    end else begin
      if (alu_op != 4'd7) nonclr_cycles++;
      if (alu_op == 4'd1) lsh_cycles++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out: got out_valid data=%0h err=%0b, required none", out_data, out_err);
        end else begin
          if (!mon_seen) begin
            mon_seen  = 1'b1;
            held_data = out_data;
            held_err  = out_err;
            chk("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
          end else begin
            chk("hold_data", 32'(out_data), 32'(held_data));
            chk("hold_err", 32'(out_err), 32'(held_err));
          end
          if (out_ready) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            chk("out_err", 32'(out_err), 32'(err_q[0]));
            void'(exp_q.pop_front());
            void'(err_q.pop_front());
            void'(lat_q.pop_front());
            void'(acc_q.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  // driver: present one op at a negedge where in_ready is high
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [CW-1:0] cnt, input logic [W-1:0] ed, input logic ee,
                      input int lat, input bit push);
    int guard = 0;
    @(negedge Clk);
    while (!in_ready && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL in_ready_timeout: got in_ready=0 for 200 cycles, required 1");
      return;
    end
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_cnt   = cnt;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(ed);
      err_q.push_back(ee);
      lat_q.push_back(lat);
      acc_q.push_back(cyc);
    end
    @(posedge Clk);
    #1 in_valid = 1'b0;
  endtask

  // wait for the scoreboard to empty, bounded
  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
      exp_q.delete();
      err_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    Reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_cnt    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd7);
    chk("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;

    // ADD 5+3
    send(4'd0, 8'h05, 8'h03, 4'd0, 8'h08, 1'b0, 2, 1'b1);
    drain();

    // LSH 1 by 3: exactly three LSH cycles at the ALU
    lsh_cycles = 0;
    send(4'd1, 8'h01, 8'h00, 4'd3, 8'h08, 1'b0, 4, 1'b1);
    drain();
    chk("lsh3_alu_cycles", 32'(lsh_cycles), 32'd3);

    // RSH by 0: no ALU step
    nonclr_cycles = 0;
    send(4'd2, 8'hA5, 8'h00, 4'd0, 8'hA5, 1'b0, 1, 1'b1);
    drain();
    chk("rsh0_alu_idle", 32'(nonclr_cycles), 32'd0);

    // LSH by 15 clamps to 8 steps
    lsh_cycles = 0;
    send(4'd1, 8'hFF, 8'h00, 4'd15, 8'h00, 1'b0, 9, 1'b1);
    drain();
    chk("lsh15_alu_cycles", 32'(lsh_cycles), 32'd8);

    // illegal op, error sticks past handshake, then cleared by a legal op
    send(4'hF, 8'h12, 8'h34, 4'd0, 8'h00, 1'b1, 1, 1'b1);
    drain();
    @(negedge Clk);
    chk("err_sticky", 32'(out_err), 32'd1);
    send(4'd0, 8'h10, 8'h20, 4'd0, 8'h30, 1'b0, 2, 1'b1);
    drain();

    // remaining EXEC ops and shift corners
    send(4'd3, 8'h0F, 8'hF0, 4'd0, 8'hFF, 1'b0, 2, 1'b1);
    send(4'd4, 8'hAA, 8'hFF, 4'd0, 8'h55, 1'b0, 2, 1'b1);
    send(4'd5, 8'h3C, 8'h0F, 4'd0, 8'h0C, 1'b0, 2, 1'b1);
    send(4'd7, 8'h3C, 8'h0F, 4'd0, 8'h00, 1'b0, 2, 1'b1);
    send(4'd8, 8'h3C, 8'h00, 4'd0, 8'hC3, 1'b0, 2, 1'b1);
    send(4'd2, 8'h80, 8'h00, 4'd3, 8'h10, 1'b0, 4, 1'b1);
    send(4'd1, 8'h81, 8'h00, 4'd1, 8'h02, 1'b0, 2, 1'b1);
    send(4'd2, 8'hFF, 8'h00, 4'd8, 8'h00, 1'b0, 9, 1'b1);
    send(4'd2, 8'hFF, 8'h00, 4'd9, 8'h00, 1'b0, 9, 1'b1);
    send(4'd9, 8'h55, 8'h55, 4'd0, 8'h00, 1'b1, 1, 1'b1);
    drain();

    // SUB under backpressure: result held, no new accept
    out_ready = 1'b0;
    send(4'd6, 8'h09, 8'h04, 4'd0, 8'h05, 1'b0, 2, 1'b1);
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(negedge Clk);
      guard++;
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge Clk);
    #1 out_ready = 1'b1;
    drain();

    // reset during SHIFT: abort, no result
    send(4'd1, 8'h01, 8'h00, 4'd8, 8'h00, 1'b0, 0, 1'b0);
    repeat (3) @(negedge Clk);
    chk("mid_shift_state", 32'(state_dbg), 32'd2);
    Reset = 1'b1;
    #1;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_alu_op", 32'(alu_op), 32'd7);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end

    // normal traffic after the abort
    send(4'd0, 8'hFE, 8'h03, 4'd0, 8'h01, 1'b0, 2, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
